// File: rtl/xor_descrambler_if.sv
// Serial valid/ready bit channel into and out of the x^7+x^6+1 descrambler.
// The master side sources scrambled bits and sinks plain bits; the slave is the descrambler.
interface xor_descrambler_if;
  logic din;
  logic in_valid;
  logic in_ready;
  logic dout;
  logic out_valid;
  logic out_ready;
  logic out_lock;

  modport master (
    output din, in_valid, out_ready,
    input  in_ready, dout, out_valid, out_lock
  );

  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, dout, out_valid, out_lock
  );
endinterface

// File: rtl/xor_descrambler.sv
// Self-synchronizing serial descrambler: dout_k = din_k ^ din_(k-TAP_A) ^ din_(k-TAP_B),
// with a one-entry output register and a lock flag once the history holds LEN received bits.
module xor_descrambler #(
  parameter int LEN   = 7,
  parameter int TAP_A = 6,
  parameter int TAP_B = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  xor_descrambler_if.slave bus
);

  localparam int FILL_W = $clog2(LEN + 1);

  if (LEN < 2 || TAP_A < 1 || TAP_A >= TAP_B || TAP_B != LEN) begin : g_bad_param
    $error("xor_descrambler: invalid LEN/TAP_A/TAP_B combination");
  end

  typedef enum logic {
    S_FILL   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  function automatic logic descramble(input logic bit_in, input logic [LEN-1:0] hist);
    return bit_in ^ hist[TAP_A-1] ^ hist[TAP_B-1];
  endfunction

  logic [LEN-1:0]    sr;
  logic [FILL_W-1:0] fill;
  state_t            state;
  logic              dout_p0;
  logic              vld_p0;
  logic              lock_p0;
  logic              accept;

  // Input side: the output register frees up in the same cycle it drains, so no bubble.
  assign bus.in_ready = !clear && (!vld_p0 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage p0: history shift, descrambled bit, valid and lock all register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      fill    <= '0;
      state   <= S_FILL;
      dout_p0 <= 1'b0;
      vld_p0  <= 1'b0;
      lock_p0 <= 1'b0;
    end else if (clear) begin
      sr      <= '0;
      fill    <= '0;
      state   <= S_FILL;
      vld_p0  <= 1'b0;
      lock_p0 <= 1'b0;
    end else if (accept) begin
      sr      <= {sr[LEN-2:0], bus.din};
      dout_p0 <= descramble(bus.din, sr);
      vld_p0  <= 1'b1;
      if (state == S_FILL) begin
        if (fill == FILL_W'(LEN - 1)) begin
          fill    <= FILL_W'(LEN);
          state   <= S_LOCKED;
          lock_p0 <= 1'b1;
        end else begin
          fill <= fill + 1'b1;
        end
      end
    end else if (vld_p0 && bus.out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign bus.dout      = dout_p0;
  assign bus.out_valid = vld_p0;
  assign bus.out_lock  = lock_p0;

endmodule
